// File: rtl/digit_renderer.sv
// digit_renderer: multi-digit glyph renderer for the VGA clock display.
// Maps a block coordinate to a lit/unlit bit through a 3-stage pipeline:
// slot/column decode, glyph selection with shadowing/blanking, font lookup.
// The font image is a constant parameter: word at address code*FONT_H+row
// lives at bits [addr*FONT_W +: FONT_W], word MSB = leftmost column.
module digit_renderer #(
  parameter int NUM_DIGITS   = 6,
  parameter int FONT_W       = 3,
  parameter int FONT_H       = 5,
  parameter int GAP          = 1,
  parameter int X_ORIGIN     = 0,
  parameter int Y_ORIGIN     = 0,
  parameter int BLINK_FRAMES = 30,
  parameter logic [16*FONT_H*FONT_W-1:0] FONT_IMAGE = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5:0]              x_block,
  input  logic [5:0]              y_block,
  input  logic                    in_valid,
  input  logic                    frame_tick,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic                    pixel_on,
  output logic                    pixel_valid
);

  localparam int PITCH     = FONT_W + GAP;
  localparam int ROM_DEPTH = 16 * FONT_H;
  localparam int SLOT_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int COL_W     = (PITCH > 1) ? $clog2(PITCH) : 1;
  localparam int ROW_W     = $clog2(FONT_H);
  localparam int ADDR_W    = $clog2(ROM_DEPTH);
  localparam int CNT_W     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // frame-synchronous state
  logic [4*NUM_DIGITS-1:0] shadow_q;
  logic [NUM_DIGITS-1:0]   lz_q;
  logic [NUM_DIGITS-1:0]   lz_next;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;

  // stage 1
  logic signed [6:0]  rx, ry;
  int                 rx_i, ry_i;
  logic [SLOT_W-1:0]  slot_n;
  logic [COL_W-1:0]   col_n;
  logic               in_x, in_y;
  logic               v1, vis1;
  logic [SLOT_W-1:0]  slot1;
  logic [COL_W-1:0]   col1;
  logic [ROW_W-1:0]   row1;

  // stage 2
  logic [3:0]         code_sel, code;
  logic               force_blank;
  logic [ADDR_W-1:0]  addr_n;
  logic               v2, vis2;
  logic [COL_W-1:0]   col2;
  logic [ADDR_W-1:0]  rom_addr;

  // stage 3
  logic [FONT_W-1:0]  rom_word;
  logic               lit;

  // Leading-zero run: a slot blanks only while every slot to its left is zero.
  // The rightmost slot is excluded so a value of zero still shows one digit.
  always_comb begin
    logic run;
    lz_next = '0;
    run     = lz_en;
    for (int i = 0; i < NUM_DIGITS - 1; i++) begin
      run        = run & (digits[4*i +: 4] == 4'd0);
      lz_next[i] = run;
    end
  end

  // Capture digits and the blanking mask once per frame so a frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q <= '1;
      lz_q     <= '0;
    end else if (frame_tick) begin
      shadow_q <= digits;
      lz_q     <= lz_next;
    end
  end

  // Blink half-period counter in frames; phase 1 hides the masked slots.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  // Decode slot and column with a compare chain against slot start offsets.
  always_comb begin
    rx     = 7'(signed'({1'b0, x_block}) - X_ORIGIN);
    ry     = 7'(signed'({1'b0, y_block}) - Y_ORIGIN);
    rx_i   = int'(rx);
    ry_i   = int'(ry);
    slot_n = '0;
    col_n  = '0;
    in_x   = 1'b0;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      if (rx_i >= s * PITCH && rx_i < s * PITCH + FONT_W) begin
        in_x   = 1'b1;
        slot_n = SLOT_W'(s);
        col_n  = COL_W'(rx_i - s * PITCH);
      end
    end
    in_y = (ry_i >= 0) && (ry_i < FONT_H);
  end

  // Stage 1 register: decoded position and visibility.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1    <= 1'b0;
      vis1  <= 1'b0;
      slot1 <= '0;
      col1  <= '0;
      row1  <= '0;
    end else begin
      v1    <= in_valid;
      vis1  <= in_valid & in_x & in_y;
      slot1 <= slot_n;
      col1  <= col_n;
      row1  <= ROW_W'(ry_i);
    end
  end

  // Pick the shadowed code for the slot, forcing the blank glyph when hidden.
  always_comb begin
    code_sel    = 4'hF;
    force_blank = 1'b0;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      if (slot1 == SLOT_W'(s)) begin
        code_sel    = shadow_q[4*s +: 4];
        force_blank = lz_q[s] | (blink_phase & blink_mask[s]);
      end
    end
    code   = force_blank ? 4'hF : code_sel;
    addr_n = ADDR_W'(int'(code) * FONT_H + int'(row1));
  end

  // Stage 2 register: font address plus column to pick out.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2       <= 1'b0;
      vis2     <= 1'b0;
      col2     <= '0;
      rom_addr <= '0;
    end else begin
      v2       <= v1;
      vis2     <= vis1;
      col2     <= col1;
      rom_addr <= addr_n;
    end
  end

  // Font lookup and column select, leftmost column in the word MSB.
  always_comb begin
    rom_word = '0;
    for (int a = 0; a < ROM_DEPTH; a++) begin
      if (rom_addr == ADDR_W'(a)) rom_word = FONT_IMAGE[a*FONT_W +: FONT_W];
    end
    lit = 1'b0;
    for (int c = 0; c < FONT_W; c++) begin
      if (col2 == COL_W'(c)) lit = rom_word[FONT_W-1-c];
    end
  end

  // Stage 3 register: final pixel and its valid flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_on    <= 1'b0;
      pixel_valid <= 1'b0;
    end else begin
      pixel_on    <= vis2 & lit;
      pixel_valid <= v2;
    end
  end

endmodule

// File: tb/tb_digit_renderer.sv
// tb_digit_renderer: scoreboard bench for digit_renderer with a small test font.
module tb_digit_renderer;

  localparam int ND = 6;
  localparam int FW = 3;
  localparam int FH = 5;
  localparam int BF = 2;

  // Test glyphs: 8 = 7,5,7,5,7; 1 = 2s; 10 = colon; 0 = 7,5,5,5,7; rest blank.
  function automatic logic [FW-1:0] glyph_row(input int code, input int row);
    case (code)
      0:       return (row == 0 || row == 4) ? 3'd7 : 3'd5;
      1:       return 3'd2;
      8:       return (row % 2 == 0) ? 3'd7 : 3'd5;
      10:      return (row % 2 == 1) ? 3'd2 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [16*FH*FW-1:0] make_font();
    logic [16*FH*FW-1:0] f;
    f = '0;
    for (int c = 0; c < 16; c++)
      for (int r = 0; r < FH; r++)
        f[(c*FH + r)*FW +: FW] = glyph_row(c, r);
    return f;
  endfunction

  localparam logic [16*FH*FW-1:0] TEST_FONT = make_font();

  logic            clk = 1'b0;
  logic            reset;
  logic [5:0]      x_block, y_block;
  logic            in_valid, frame_tick;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   blink_mask;
  logic            lz_en;
  logic            pixel_on, pixel_valid;

  digit_renderer #(
    .NUM_DIGITS(ND), .FONT_W(FW), .FONT_H(FH), .GAP(1),
    .X_ORIGIN(0), .Y_ORIGIN(0), .BLINK_FRAMES(BF), .FONT_IMAGE(TEST_FONT)
  ) dut (
    .clk(clk), .reset(reset), .x_block(x_block), .y_block(y_block),
    .in_valid(in_valid), .frame_tick(frame_tick), .digits(digits),
    .blink_mask(blink_mask), .lz_en(lz_en),
    .pixel_on(pixel_on), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v;
    logic on;
    int   x;
    int   y;
  } exp_t;

  exp_t  exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string phase_tag = "init";

  // reference state
  int   m_shadow[ND];
  logic m_lz[ND];
  int   m_cnt;
  logic m_phase;

  task automatic check_bit(input string tag, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < ND; i++) begin
      m_shadow[i] = 15;
      m_lz[i]     = 1'b0;
    end
    m_cnt   = 0;
    m_phase = 1'b0;
  endtask

  task automatic m_tick();
    logic all_zero;
    all_zero = lz_en;
    for (int i = 0; i < ND; i++) begin
      m_shadow[i] = int'(digits[4*i +: 4]);
      all_zero    = all_zero && (m_shadow[i] == 0);
      m_lz[i]     = (i < ND - 1) ? all_zero : 1'b0;
    end
    if (m_cnt == BF - 1) begin
      m_cnt   = 0;
      m_phase = ~m_phase;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  function automatic logic model_pixel(input int x, input int y);
    int   slot, col, code;
    logic [FW-1:0] r;
    if (y < 0 || y >= FH || x < 0) return 1'b0;
    slot = x / (FW + 1);
    col  = x % (FW + 1);
    if (slot >= ND || col >= FW) return 1'b0;
    code = m_shadow[slot];
    if (m_lz[slot] || (m_phase && blink_mask[slot])) code = 15;
    r = glyph_row(code, y);
    return r[FW-1-col];
  endfunction

  task automatic step(input int x, input int y, input logic v, input logic tick);
    exp_t e;
    x_block    = 6'(x);
    y_block    = 6'(y);
    in_valid   = v;
    frame_tick = tick;
    if (tick) m_tick();
    e.v  = v;
    e.on = v ? model_pixel(x, y) : 1'b0;
    e.x  = x;
    e.y  = y;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    if (exp_q.size() >= 3) begin
      e = exp_q.pop_front();
      check_bit($sformatf("%s valid x=%0d y=%0d", phase_tag, e.x, e.y), pixel_valid, e.v);
      check_bit($sformatf("%s pixel x=%0d y=%0d", phase_tag, e.x, e.y), pixel_on, e.on);
    end
  endtask

  task automatic do_reset();
    exp_t z;
    reset      = 1'b1;
    in_valid   = 1'b1;
    frame_tick = 1'b1;
    x_block    = 6'd0;
    y_block    = 6'd0;
    @(posedge clk);
    #1;
    reset      = 1'b0;
    frame_tick = 1'b0;
    in_valid   = 1'b0;
    exp_q.delete();
    z.v = 1'b0; z.on = 1'b0; z.x = -1; z.y = -1;
    exp_q.push_back(z);
    exp_q.push_back(z);
    m_reset();
    check_bit("reset valid", pixel_valid, 1'b0);
    check_bit("reset pixel", pixel_on, 1'b0);
  endtask

  task automatic sweep(input int y_lo, input int y_hi, input int x_hi);
    for (int y = y_lo; y <= y_hi; y++)
      for (int x = 0; x <= x_hi; x++)
        step(x, y, 1'b1, 1'b0);
  endtask

  task automatic tick_idle();
    step(0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    reset      = 1'b1;
    x_block    = '0;
    y_block    = '0;
    in_valid   = 1'b0;
    frame_tick = 1'b0;
    digits     = {ND{4'h8}};
    blink_mask = '0;
    lz_en      = 1'b0;
    m_reset();
    do_reset();
    do_reset();

    phase_tag = "blank";
    for (int y = 0; y < FH; y++)
      for (int x = 0; x < 24; x++)
        step(x, y, (x % 3) != 2, 1'b0);

    digits = {ND{4'h8}};
    tick_idle();
    phase_tag = "eights";
    sweep(0, FH, 27);

    digits = {ND{4'h1}};
    phase_tag = "hold";
    sweep(1, 1, 23);
    tick_idle();
    phase_tag = "ones";
    sweep(0, 1, 23);

    lz_en  = 1'b1;
    digits = 24'h000100;
    tick_idle();
    phase_tag = "lz";
    sweep(0, FH - 1, 23);

    digits = '0;
    tick_idle();
    phase_tag = "lz_all0";
    sweep(0, FH - 1, 23);

    lz_en  = 1'b0;
    digits = {4'h0, 4'hF, 4'hA, 4'h8, 4'h1, 4'h0};
    step(5, 1, 1'b1, 1'b1);
    phase_tag = "mix";
    sweep(0, FH - 1, 23);

    do_reset();
    blink_mask = 6'b000001;
    digits     = {ND{4'h8}};
    for (int t = 1; t <= 5; t++) begin
      tick_idle();
      phase_tag = $sformatf("blink%0d", t);
      sweep(0, 1, 8);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);
    blink_mask = '0;

    tick_idle();
    phase_tag = "midrst";
    for (int x = 0; x < 24; x++) begin
      if (x == 10) do_reset();
      else step(x, 0, 1'b1, 1'b0);
    end
    tick_idle();
    phase_tag = "after_rst";
    sweep(0, 0, 23);

    for (int i = 0; i < 3; i++) step(0, 0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
